// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and flag indices for the sequential ALU.
// Imported by the interface, datapath and top.
package alu_pkg;

  localparam logic [2:0] OP_AND   = 3'b000;
  localparam logic [2:0] OP_OR    = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_LSL   = 3'b100;
  localparam logic [2:0] OP_LSR   = 3'b101;
  localparam logic [2:0] OP_MUL   = 3'b110;
  localparam logic [2:0] OP_PASSB = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int FL_NEG   = 0;
  localparam int FL_ZERO  = 1;
  localparam int FL_OVF   = 2;
  localparam int FL_CARRY = 3;
  localparam int FL_W     = 4;

endpackage

// File: rtl/alu_seq_if.sv
// Request/result handshake bundle between EX control and the ALU.
// slave = ALU side, master = issuing side.
interface alu_seq_if #(
  parameter int W     = 64,
  parameter int SHW   = $clog2(W),
  parameter int TAG_W = 5
) ();
  import alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     A;
  logic [W-1:0]     B;
  logic [SHW-1:0]   SHAMT;
  logic [2:0]       cntrl;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     result;
  logic             negative;
  logic             zero;
  logic             overflow;
  logic             carry_out;
  logic [TAG_W-1:0] tag_out;

  modport slave (
    input  in_valid, A, B, SHAMT, cntrl, tag_in,
    input  out_ready,
    output in_ready, out_valid, result,
    output negative, zero, overflow, carry_out,
    output tag_out
  );

  modport master (
    output in_valid, A, B, SHAMT, cntrl, tag_in,
    output out_ready,
    input  in_ready, out_valid, result,
    input  negative, zero, overflow, carry_out,
    input  tag_out
  );

endinterface

// File: rtl/alu_seq_comb.sv
// Single-cycle datapath: every op except MUL, plus flag generation.
// Carry/overflow come from one extra bit on the add/sub/shift paths.
module alu_seq_comb
  import alu_pkg::*;
#(
  parameter int W   = 64,
  parameter int SHW = $clog2(W)
) (
  input  logic [W-1:0]    a_i,
  input  logic [W-1:0]    b_i,
  input  logic [SHW-1:0]  shamt_i,
  input  logic [2:0]      op_i,
  output logic [W-1:0]    res_o,
  output logic [FL_W-1:0] flags_o
);

  logic [W:0] add_w;
  logic [W:0] sub_w;
  logic [W:0] lsl_w;
  logic [W:0] lsr_w;
  logic       ovf;
  logic       cy;

  assign add_w = {1'b0, a_i} + {1'b0, b_i};
  assign sub_w = {1'b0, a_i} - {1'b0, b_i};
  // Extra bit catches the last bit shifted out
  assign lsl_w = {1'b0, a_i} << shamt_i;
  assign lsr_w = {a_i, 1'b0} >> shamt_i;

  always_comb begin
    res_o = '0;
    ovf   = 1'b0;
    cy    = 1'b0;
    unique case (1'b1)
      (op_i == OP_AND):   res_o = a_i & b_i;
      (op_i == OP_OR):    res_o = a_i | b_i;
      (op_i == OP_ADD): begin
        res_o = add_w[W-1:0];
        cy    = add_w[W];
        ovf   = (a_i[W-1] == b_i[W-1]) &&
                (add_w[W-1] != a_i[W-1]);
      end
      (op_i == OP_SUB): begin
        res_o = sub_w[W-1:0];
        cy    = ~sub_w[W];
        ovf   = (a_i[W-1] != b_i[W-1]) &&
                (sub_w[W-1] != a_i[W-1]);
      end
      (op_i == OP_LSL): begin
        res_o = lsl_w[W-1:0];
        cy    = lsl_w[W];
      end
      (op_i == OP_LSR): begin
        res_o = lsr_w[W:1];
        cy    = lsr_w[0];
      end
      (op_i == OP_PASSB): res_o = b_i;
      default:            res_o = '0;
    endcase
    flags_o           = '0;
    flags_o[FL_NEG]   = res_o[W-1];
    flags_o[FL_ZERO]  = ~|res_o;
    flags_o[FL_OVF]   = ovf;
    flags_o[FL_CARRY] = cy;
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: registered result stage, W-cycle shift-add multiply,
// tag passthrough so EX control can match results to instructions.
module alu_seq
  import alu_pkg::*;
#(
  parameter int W     = 64,
  parameter int SHW   = $clog2(W),
  parameter int TAG_W = 5
) (
  input  logic       clk,
  input  logic       rst,
  alu_seq_if.slave   bus
);

  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(W-1);

  state_e           state_q;
  logic [W-1:0]     result_q;
  logic [FL_W-1:0]  flags_q;
  logic [TAG_W-1:0] tag_q;
  logic [TAG_W-1:0] mtag_q;
  logic [2*W-1:0]   mcand_q;
  logic [2*W-1:0]   acc_q;
  logic [W-1:0]     mplier_q;
  logic [SHW:0]     cnt_q;

  logic [2*W-1:0]   acc_d;
  logic [FL_W-1:0]  mflags_d;
  logic [W-1:0]     c_res;
  logic [FL_W-1:0]  c_flags;
  logic             accept;

  alu_seq_comb #(
    .W   (W),
    .SHW (SHW)
  ) u_comb (
    .a_i     (bus.A),
    .b_i     (bus.B),
    .shamt_i (bus.SHAMT),
    .op_i    (bus.cntrl),
    .res_o   (c_res),
    .flags_o (c_flags)
  );

  assign bus.in_ready = (state_q == ST_IDLE) ||
                        (state_q == ST_DONE && bus.out_ready);
  assign accept = bus.in_valid && bus.in_ready;

  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.result    = result_q;
  assign bus.negative  = flags_q[FL_NEG];
  assign bus.zero      = flags_q[FL_ZERO];
  assign bus.overflow  = flags_q[FL_OVF];
  assign bus.carry_out = flags_q[FL_CARRY];
  assign bus.tag_out   = tag_q;

  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    mflags_d           = '0;
    mflags_d[FL_NEG]   = acc_d[W-1];
    mflags_d[FL_ZERO]  = ~|acc_d[W-1:0];
    mflags_d[FL_OVF]   = |acc_d[2*W-1:W];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      flags_q  <= '0;
      tag_q    <= '0;
      mtag_q   <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (bus.cntrl == OP_MUL) begin
              // tag_out must not move until the product lands
              mtag_q   <= bus.tag_in;
              mcand_q  <= {{W{1'b0}}, bus.A};
              mplier_q <= bus.B;
              acc_q    <= '0;
              cnt_q    <= '0;
              state_q  <= ST_BUSY;
            end else begin
              result_q <= c_res;
              flags_q  <= c_flags;
              tag_q    <= bus.tag_in;
              state_q  <= ST_DONE;
            end
          end else if (state_q == ST_DONE && bus.out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            result_q <= acc_d[W-1:0];
            flags_q  <= mflags_d;
            tag_q    <= mtag_q;
            state_q  <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: W=64 instance for the main plan,
// W=32 instance for the tag passthrough case.
module tb_alu_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  alu_seq_if #(.W(64), .TAG_W(5)) bus64 ();
  alu_seq_if #(.W(32), .TAG_W(5)) bus32 ();

  alu_seq #(.W(64), .TAG_W(5)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus64.slave)
  );

  alu_seq #(.W(32), .TAG_W(5)) u_dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32.slave)
  );

  logic [2:0]  ops   [7] = '{3'd0, 3'd1, 3'd2, 3'd3,
                             3'd4, 3'd5, 3'd7};
  logic [63:0] exp_r [7] = '{64'd0, 64'd7, 64'd7, 64'd1,
                             64'h400, 64'd0, 64'd3};
  logic [3:0]  exp_f [7] = '{4'b0100, 4'b0000, 4'b0000,
                             4'b0001, 4'b0000, 4'b0100,
                             4'b0000};

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  // flags packed as {negative, zero, overflow, carry_out}
  task automatic chk_out(input string tag,
                         input logic [63:0] r,
                         input logic [3:0] f,
                         input logic [4:0] t);
    chk({tag, "_valid"}, 64'(bus64.out_valid), 64'd1);
    chk({tag, "_res"}, bus64.result, r);
    chk({tag, "_flags"},
        64'({bus64.negative, bus64.zero,
             bus64.overflow, bus64.carry_out}), 64'(f));
    chk({tag, "_tag"}, 64'(bus64.tag_out), 64'(t));
  endtask

  task automatic send(input logic [2:0] op,
                      input logic [63:0] a,
                      input logic [63:0] b,
                      input logic [5:0] sh,
                      input logic [4:0] tg);
    bus64.cntrl    = op;
    bus64.A        = a;
    bus64.B        = b;
    bus64.SHAMT    = sh;
    bus64.tag_in   = tg;
    bus64.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus64.in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int ok;
    bus64.in_valid  = 1'b0;
    bus64.out_ready = 1'b1;
    bus64.A         = '0;
    bus64.B         = '0;
    bus64.SHAMT     = '0;
    bus64.cntrl     = '0;
    bus64.tag_in    = '0;
    bus32.in_valid  = 1'b0;
    bus32.out_ready = 1'b1;
    bus32.A         = '0;
    bus32.B         = '0;
    bus32.SHAMT     = '0;
    bus32.cntrl     = '0;
    bus32.tag_in    = '0;

    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_valid", 64'(bus64.out_valid), 64'd0);
    chk("rst_res", bus64.result, 64'd0);
    chk("rst_flags",
        64'({bus64.negative, bus64.zero,
             bus64.overflow, bus64.carry_out}), 64'd0);
    chk("rst_tag", 64'(bus64.tag_out), 64'd0);
    chk("rst_ready", 64'(bus64.in_ready), 64'd1);

    // back-to-back single-cycle ops, one result per cycle
    bus64.A     = 64'd4;
    bus64.B     = 64'd3;
    bus64.SHAMT = 6'd8;
    for (int i = 0; i < 7; i++) begin
      if (i > 0)
        chk_out($sformatf("b2b%0d", i-1),
                exp_r[i-1], exp_f[i-1], 5'(i-1));
      chk($sformatf("b2b_rdy%0d", i),
          64'(bus64.in_ready), 64'd1);
      bus64.cntrl    = ops[i];
      bus64.tag_in   = 5'(i);
      bus64.in_valid = 1'b1;
      @(negedge clk);
    end
    bus64.in_valid = 1'b0;
    chk_out("b2b6", exp_r[6], exp_f[6], 5'd6);

    @(negedge clk);
    send(OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 6'd0, 5'd1);
    @(negedge clk);
    chk_out("add_ovf", 64'h8000_0000_0000_0000, 4'b1010, 5'd1);

    @(negedge clk);
    send(OP_SUB, 64'd3, 64'd4, 6'd0, 5'd2);
    @(negedge clk);
    chk_out("sub_neg", 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 5'd2);

    // MUL 4*3: busy for 64 cycles
    @(negedge clk);
    send(OP_MUL, 64'd4, 64'd3, 6'd0, 5'd5);
    ok = 0;
    repeat (64) begin
      @(negedge clk);
      if (!bus64.in_ready && !bus64.out_valid) ok++;
    end
    chk("mul_busy", 64'(ok), 64'd64);
    @(negedge clk);
    chk_out("mul12", 64'd12, 4'b0000, 5'd5);

    @(negedge clk);
    send(OP_MUL, 64'h8000_0000_0000_0000, 64'd2, 6'd0, 5'd6);
    repeat (64) @(negedge clk);
    chk("mul_hi_pre", 64'(bus64.out_valid), 64'd0);
    @(negedge clk);
    chk_out("mul_hi", 64'd0, 4'b0110, 5'd6);

    // backpressure after ADD
    @(negedge clk);
    bus64.out_ready = 1'b0;
    send(OP_ADD, 64'd10, 64'd20, 6'd0, 5'd3);
    ok = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus64.out_valid && bus64.result == 64'd30 &&
          bus64.tag_out == 5'd3 && !bus64.in_ready) ok++;
    end
    chk("bp_hold", 64'(ok), 64'd10);
    @(negedge clk);
    bus64.cntrl     = OP_OR;
    bus64.A         = 64'd5;
    bus64.B         = 64'd2;
    bus64.tag_in    = 5'd9;
    bus64.in_valid  = 1'b1;
    bus64.out_ready = 1'b1;
    #1;
    chk("bp_ready", 64'(bus64.in_ready), 64'd1);
    @(posedge clk);
    #1 bus64.in_valid = 1'b0;
    @(negedge clk);
    chk_out("bp_next", 64'd7, 4'b0000, 5'd9);

    // reset in BUSY cycle 20
    @(negedge clk);
    send(OP_MUL, 64'd4, 64'd3, 6'd0, 5'd4);
    repeat (20) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mrst_valid", 64'(bus64.out_valid), 64'd0);
    chk("mrst_res", bus64.result, 64'd0);
    chk("mrst_flags",
        64'({bus64.negative, bus64.zero,
             bus64.overflow, bus64.carry_out}), 64'd0);
    chk("mrst_ready", 64'(bus64.in_ready), 64'd1);
    send(OP_ADD, 64'd4, 64'd3, 6'd0, 5'd7);
    @(negedge clk);
    chk_out("mrst_add", 64'd7, 4'b0000, 5'd7);

    // W=32 tag passthrough
    @(negedge clk);
    bus32.cntrl    = OP_LSL;
    bus32.A        = 32'd1;
    bus32.SHAMT    = 5'd31;
    bus32.tag_in   = 5'd31;
    bus32.in_valid = 1'b1;
    @(posedge clk);
    #1 bus32.in_valid = 1'b0;
    @(negedge clk);
    chk("w32_valid", 64'(bus32.out_valid), 64'd1);
    chk("w32_res", 64'(bus32.result), 64'h8000_0000);
    chk("w32_flags",
        64'({bus32.negative, bus32.zero,
             bus32.overflow, bus32.carry_out}), 64'b1000);
    chk("w32_tag", 64'(bus32.tag_out), 64'd31);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, handshaked successor to the 64-bit combinational ALU used in the 5-stage processor.
- Adds a registered output stage with valid/ready flow control and an iterative multi-cycle unsigned multiply.
- Adds a passthrough tag so EX-stage control can match results to the instructions that issued them.
- Single-cycle ops complete in 1 cycle; MUL takes W cycles.

Parameters:
W, 64, datapath width (>=8, power of 2)
SHW, $clog2(W), shift-amount width
TAG_W, 5, tag width (destination register index)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-low
in_valid  in  1  operation request
in_ready  out  1  block can accept a request this cycle
A  in  W  operand A
B  in  W  operand B
SHAMT  in  SHW  shift amount
cntrl  in  3  opcode
tag_in  in  TAG_W  request tag
out_valid  out  1  result/flags valid
out_ready  in  1  consumer accepts result
result  out  W  result
negative, zero, overflow, carry_out  out  1 each  flags
tag_out  out  TAG_W  tag of the current result

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low (rst == 0 at a clk edge).
- Opcodes:
  - 000 AND, 001 OR, 010 ADD, 011 SUB (A-B), 100 LSL (A<<SHAMT), 101 LSR (A>>SHAMT), 110 MUL (low W bits of A*B, unsigned), 111 PASSB.
- Flags:
  - negative = result[W-1]; zero = (result == 0).
  - ADD: carry_out = unsigned carry out of bit W-1; overflow = signed overflow.
  - SUB: carry_out = 1 when no borrow (A >= B unsigned); overflow = signed overflow.
  - LSL/LSR: carry_out = last bit shifted out (0 when SHAMT == 0); overflow = 0.
  - MUL: overflow = 1 when the upper W product bits are nonzero; carry_out = 0.
  - AND/OR/PASSB: overflow = 0, carry_out = 0.
- Acceptance: a request is accepted at a rising edge where in_valid && in_ready. Inputs are sampled only at acceptance.
- FSM states IDLE, BUSY, DONE:
  - in_ready = (state == IDLE) || (state == DONE && out_ready).
  - IDLE, accept non-MUL: register result, flags and tag; next state DONE (latency 1: out_valid high the cycle after acceptance).
  - IDLE, accept MUL: load multiplicand = A, multiplier = B, acc = 0, hi-nonzero tracker = 0, count = 0; next state BUSY.
  - BUSY: each cycle, if multiplier[0], add the shifted multiplicand into the 2W-bit acc; shift; count++. On the cycle count == W-1, write result and flags and go to DONE. out_valid rises exactly W cycles after acceptance.
  - DONE: out_valid = 1; result, flags and tag_out are held stable while out_ready = 0.
  - DONE with out_ready = 1: if a new request is accepted in the same cycle, follow the IDLE transitions above (back-to-back, no bubble); otherwise go to IDLE.
- Outputs:
  - out_valid is 1 only in DONE.
  - result, flags and tag_out are registered; they keep the last value when not in DONE.
- Reset:
  - On reset: state = IDLE, out_valid = 0, result = 0, all flags 0, tag_out = 0, count = 0, acc = 0; in_ready = 1 from the cycle after the reset edge.
  - Reset during BUSY or DONE aborts the operation; no result is produced for it.
  - in_valid is ignored on reset edges.
- No internal wrap: count is SHW+1 bits wide, so reaching W-1 cannot alias.

Decomposition:
- Package alu_pkg:
  - opcode localparams OP_AND..OP_PASSB;
  - FSM state encoding ST_IDLE/ST_BUSY/ST_DONE;
  - flag-index constants.
- Sub-module alu_seq_comb: combinational single-cycle datapath (non-MUL ops plus flag generation), parametrised by W and SHW.
- The MUL iteration and the FSM live in alu_seq.

Test Plan:
- W=64; A=4, B=3, SHAMT=8, out_ready=1; issue cntrl 000..101 and 111 back-to-back -> one result per cycle, one cycle after each acceptance:
  - AND: result 0, zero=1.
  - OR: result 7.
  - ADD: result 7, all flags 0.
  - SUB: result 1, carry_out=1.
  - LSL: result 0x400.
  - LSR: result 0, zero=1.
  - PASSB: result 3.
- ADD A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> result 0x8000_0000_0000_0000, negative=1, overflow=1, carry_out=0. SUB A=3, B=4 -> result all-ones, negative=1, carry_out=0.
- MUL A=4, B=3, tag_in=5 -> in_ready=0 for 64 cycles, then out_valid=1 with result 12, tag_out=5, overflow=0. MUL A=2^63, B=2 -> result 0, zero=1, overflow=1.
- Backpressure: hold out_ready=0 for 10 cycles after an ADD -> out_valid stays 1, result stable, in_ready=0. Then raise out_ready with a new request pending -> the new request is accepted in the same cycle.
- Reset mid-MUL: drive rst=0 for 1 cycle at BUSY cycle 20 -> next cycle out_valid=0, result=0, flags 0, in_ready=1. A following ADD 4+3 returns 7 after 1 cycle.
- Tag passthrough with W=32, TAG_W=5: LSL A=1, SHAMT=31, tag_in=31 -> result 0x8000_0000, negative=1, tag_out=31.
